// File: rtl/erx_disty.sv
`default_nettype none
// erx_disty: routes head-of-FIFO RX packets to the write or read-request FIFO, keeping FIFO order.
// Rev 1.0. Optional dstaddr remap is built when ERX_DISTY_REMAP_EN is defined.
module erx_disty #(
  parameter int CW = 16
) (
  input  logic          m_axi_aclk,
  input  logic          m_axi_aresetn,
  input  logic          rx_access,
  input  logic          rx_write,
  input  logic [1:0]    rx_datamode,
  input  logic [3:0]    rx_ctrlmode,
  input  logic [31:0]   rx_dstaddr,
  input  logic [31:0]   rx_data,
  input  logic [31:0]   rx_srcaddr,
  output logic          rx_rd_en,
`ifdef ERX_DISTY_REMAP_EN
  input  logic [11:0]   cfg_remap,
`endif
  output logic          emwr_access,
  output logic          emwr_write,
  output logic [1:0]    emwr_datamode,
  output logic [3:0]    emwr_ctrlmode,
  output logic [31:0]   emwr_dstaddr,
  output logic [31:0]   emwr_data,
  output logic [31:0]   emwr_srcaddr,
  output logic          emrq_access,
  output logic          emrq_write,
  output logic [1:0]    emrq_datamode,
  output logic [3:0]    emrq_ctrlmode,
  output logic [31:0]   emrq_dstaddr,
  output logic [31:0]   emrq_data,
  output logic [31:0]   emrq_srcaddr,
  input  logic          emwr_progfull,
  input  logic          emrq_progfull,
  output logic [CW-1:0] wr_count,
  output logic [CW-1:0] rq_count
);

  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t      state, state_nxt;
  logic        blocked;
  logic        pop_wr, pop_rq;
  logic [31:0] dst_fwd;

  assign blocked = rx_write ? emwr_progfull : emrq_progfull;

`ifdef ERX_DISTY_REMAP_EN
  assign dst_fwd = (rx_dstaddr[31:20] == 12'h808) ? {cfg_remap, rx_dstaddr[19:0]} : rx_dstaddr;
`else
  assign dst_fwd = rx_dstaddr;
`endif

  // Pop is purely combinational so HOLD->RUN pops in the same cycle progfull drops.
  always_comb begin
    rx_rd_en  = 1'b0;
    state_nxt = state;
    if (m_axi_aresetn) begin
      rx_rd_en = rx_access & ~blocked;
      case (state)
        RUN:     if (rx_access & blocked) state_nxt = HOLD;
        HOLD:    if (~rx_access | ~blocked) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  assign pop_wr = rx_rd_en & rx_write;
  assign pop_rq = rx_rd_en & ~rx_write;

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      emwr_access   <= 1'b0;
      emwr_write    <= 1'b1;
      emwr_datamode <= '0;
      emwr_ctrlmode <= '0;
      emwr_dstaddr  <= '0;
      emwr_data     <= '0;
      emwr_srcaddr  <= '0;
      emrq_access   <= 1'b0;
      emrq_write    <= 1'b0;
      emrq_datamode <= '0;
      emrq_ctrlmode <= '0;
      emrq_dstaddr  <= '0;
      emrq_data     <= '0;
      emrq_srcaddr  <= '0;
      wr_count      <= '0;
      rq_count      <= '0;
    end else begin
      emwr_access <= pop_wr;
      emrq_access <= pop_rq;
      emwr_write  <= 1'b1;
      emrq_write  <= 1'b0;
      if (pop_wr) begin
        emwr_datamode <= rx_datamode;
        emwr_ctrlmode <= rx_ctrlmode;
        emwr_dstaddr  <= dst_fwd;
        emwr_data     <= rx_data;
        emwr_srcaddr  <= rx_srcaddr;
        if (wr_count != CNT_MAX) wr_count <= wr_count + 1'b1;
      end
      if (pop_rq) begin
        emrq_datamode <= rx_datamode;
        emrq_ctrlmode <= rx_ctrlmode;
        emrq_dstaddr  <= dst_fwd;
        emrq_data     <= rx_data;
        emrq_srcaddr  <= rx_srcaddr;
        if (rq_count != CNT_MAX) rq_count <= rq_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_erx_disty.sv
`default_nettype none
// tb_erx_disty: scoreboard bench for erx_disty (default CW and CW=4 instances share stimulus).
module tb_erx_disty;

  typedef struct packed {
    logic        w;
    logic [1:0]  dm;
    logic [3:0]  cm;
    logic [31:0] da;
    logic [31:0] d;
    logic [31:0] sa;
  } pkt_t;

  logic clk = 1'b0;
  logic rstn;
  logic rx_access, rx_write;
  logic [1:0] rx_datamode;
  logic [3:0] rx_ctrlmode;
  logic [31:0] rx_dstaddr, rx_data, rx_srcaddr;
  logic emwr_progfull, emrq_progfull;
  logic [11:0] cfg_remap;

  logic rd_en, wr_acc, wr_wr, rq_acc, rq_wr;
  logic [1:0] wr_dm, rq_dm;
  logic [3:0] wr_cm, rq_cm;
  logic [31:0] wr_da, wr_d, wr_sa, rq_da, rq_d, rq_sa;
  logic [15:0] wr_cnt, rq_cnt;

  logic rd_en4, wr_acc4, wr_wr4, rq_acc4, rq_wr4;
  logic [1:0] wr_dm4, rq_dm4;
  logic [3:0] wr_cm4, rq_cm4;
  logic [31:0] wr_da4, wr_d4, wr_sa4, rq_da4, rq_d4, rq_sa4;
  logic [3:0] wr_cnt4, rq_cnt4;

  int total = 0;
  int bad = 0;
  pkt_t q[$];
  pkt_t last_wr, last_rq;
  int m_wr16, m_rq16, m_wr4, m_rq4;
  logic m_state;

  always #5 clk = ~clk;

  erx_disty u_dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rstn),
    .rx_access(rx_access), .rx_write(rx_write), .rx_datamode(rx_datamode),
    .rx_ctrlmode(rx_ctrlmode), .rx_dstaddr(rx_dstaddr), .rx_data(rx_data),
    .rx_srcaddr(rx_srcaddr), .rx_rd_en(rd_en),
`ifdef ERX_DISTY_REMAP_EN
    .cfg_remap(cfg_remap),
`endif
    .emwr_access(wr_acc), .emwr_write(wr_wr), .emwr_datamode(wr_dm), .emwr_ctrlmode(wr_cm),
    .emwr_dstaddr(wr_da), .emwr_data(wr_d), .emwr_srcaddr(wr_sa),
    .emrq_access(rq_acc), .emrq_write(rq_wr), .emrq_datamode(rq_dm), .emrq_ctrlmode(rq_cm),
    .emrq_dstaddr(rq_da), .emrq_data(rq_d), .emrq_srcaddr(rq_sa),
    .emwr_progfull(emwr_progfull), .emrq_progfull(emrq_progfull),
    .wr_count(wr_cnt), .rq_count(rq_cnt)
  );

  erx_disty #(.CW(4)) u_dut4 (
    .m_axi_aclk(clk), .m_axi_aresetn(rstn),
    .rx_access(rx_access), .rx_write(rx_write), .rx_datamode(rx_datamode),
    .rx_ctrlmode(rx_ctrlmode), .rx_dstaddr(rx_dstaddr), .rx_data(rx_data),
    .rx_srcaddr(rx_srcaddr), .rx_rd_en(rd_en4),
`ifdef ERX_DISTY_REMAP_EN
    .cfg_remap(cfg_remap),
`endif
    .emwr_access(wr_acc4), .emwr_write(wr_wr4), .emwr_datamode(wr_dm4), .emwr_ctrlmode(wr_cm4),
    .emwr_dstaddr(wr_da4), .emwr_data(wr_d4), .emwr_srcaddr(wr_sa4),
    .emrq_access(rq_acc4), .emrq_write(rq_wr4), .emrq_datamode(rq_dm4), .emrq_ctrlmode(rq_cm4),
    .emrq_dstaddr(rq_da4), .emrq_data(rq_d4), .emrq_srcaddr(rq_sa4),
    .emwr_progfull(emwr_progfull), .emrq_progfull(emrq_progfull),
    .wr_count(wr_cnt4), .rq_count(rq_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic acc, input logic wr, input logic [1:0] dm, input logic [3:0] cm,
                       input logic [31:0] da, input logic [31:0] d, input logic [31:0] sa);
    rx_access = acc; rx_write = wr; rx_datamode = dm; rx_ctrlmode = cm;
    rx_dstaddr = da; rx_data = d; rx_srcaddr = sa;
  endtask

  // One clock: predict pop, queue expected packet, then compare everything after the edge.
  task automatic cycle();
    logic blk, pop;
    pkt_t e, got;
    #1;
    blk = rx_write ? emwr_progfull : emrq_progfull;
    pop = rstn & rx_access & ~blk;
    check("rd_en", {63'd0, rd_en}, {63'd0, pop});
    check("rd_en4", {63'd0, rd_en4}, {63'd0, pop});
    if (pop) begin
      e = '{w: rx_write, dm: rx_datamode, cm: rx_ctrlmode, da: rx_dstaddr, d: rx_data, sa: rx_srcaddr};
`ifdef ERX_DISTY_REMAP_EN
      if (rx_dstaddr[31:20] == 12'h808) e.da = {cfg_remap, rx_dstaddr[19:0]};
`endif
      q.push_back(e);
    end
    m_state = rstn & rx_access & blk;
    if (!rstn) begin
      q.delete();
      last_wr = '0; last_wr.w = 1'b1; last_rq = '0;
      m_wr16 = 0; m_rq16 = 0; m_wr4 = 0; m_rq4 = 0;
    end else if (pop) begin
      if (rx_write) begin
        if (m_wr16 < 65535) m_wr16++;
        if (m_wr4 < 15) m_wr4++;
      end else begin
        if (m_rq16 < 65535) m_rq16++;
        if (m_rq4 < 15) m_rq4++;
      end
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.w) last_wr = e; else last_rq = e;
      check("wr_acc", {63'd0, wr_acc}, {63'd0, e.w});
      check("rq_acc", {63'd0, rq_acc}, {63'd0, ~e.w});
    end else begin
      check("wr_acc_idle", {63'd0, wr_acc}, 64'd0);
      check("rq_acc_idle", {63'd0, rq_acc}, 64'd0);
    end
    got = '{w: wr_wr, dm: wr_dm, cm: wr_cm, da: wr_da, d: wr_d, sa: wr_sa};
    check("wr_fields_hi", {42'd0, got[102:96], got[95:81]}, {42'd0, last_wr[102:96], last_wr[95:81]});
    check("wr_da", {32'd0, wr_da}, {32'd0, last_wr.da});
    check("wr_d_sa", {wr_d, wr_sa}, {last_wr.d, last_wr.sa});
    got = '{w: rq_wr, dm: rq_dm, cm: rq_cm, da: rq_da, d: rq_d, sa: rq_sa};
    check("rq_fields_hi", {42'd0, got[102:96], got[95:81]}, {42'd0, last_rq[102:96], last_rq[95:81]});
    check("rq_da", {32'd0, rq_da}, {32'd0, last_rq.da});
    check("rq_d_sa", {rq_d, rq_sa}, {last_rq.d, last_rq.sa});
    check("wr_count", {48'd0, wr_cnt}, 64'(m_wr16));
    check("rq_count", {48'd0, rq_cnt}, 64'(m_rq16));
    check("wr_count4", {60'd0, wr_cnt4}, 64'(m_wr4));
    check("rq_count4", {60'd0, rq_cnt4}, 64'(m_rq4));
    check("fsm", {63'd0, u_dut.state}, {63'd0, m_state});
  endtask

  initial begin
    cfg_remap = 12'h3E0;
    emwr_progfull = 1'b0; emrq_progfull = 1'b0;
    last_wr = '0; last_wr.w = 1'b1; last_rq = '0;
    m_wr16 = 0; m_rq16 = 0; m_wr4 = 0; m_rq4 = 0; m_state = 1'b0;
    rstn = 1'b0;
    drive(1'b1, 1'b1, 2'd1, 4'h3, 32'h1234_5678, 32'h1, 32'h2);
    @(posedge clk); #1;
    cycle(); cycle();

    // single write with identical fields
    rstn = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 4'h0, 32'h8E00_0010, 32'hA5A5_0001, 32'h0000_0000);
    cycle();
    drive(1'b0, 1'b1, 2'd3, 4'hF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h5555_5555);
    cycle();
    check("wr_count_one", {48'd0, wr_cnt}, 64'd1);

    // read then write in consecutive cycles
    drive(1'b1, 1'b0, 2'd2, 4'h1, 32'h8200_0100, 32'h0, 32'h8100_0000);
    cycle();
    drive(1'b1, 1'b1, 2'd1, 4'h2, 32'h8E00_0020, 32'hA5A5_0002, 32'h0);
    cycle();
    drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    check("rq_count_one", {48'd0, rq_cnt}, 64'd1);

    // blocked read holds a write behind it
    emrq_progfull = 1'b1;
    drive(1'b1, 1'b0, 2'd2, 4'h4, 32'h8300_0000, 32'h0, 32'h8100_0004);
    for (int i = 0; i < 3; i++) cycle();
    check("hold_state", {63'd0, u_dut.state}, 64'd1);
    emrq_progfull = 1'b0;
    cycle();
    drive(1'b1, 1'b1, 2'd2, 4'h5, 32'h8E00_0030, 32'hA5A5_0003, 32'h0);
    cycle();
    // blocked write with progfull on write side only
    emwr_progfull = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 4'h6, 32'h8E00_0040, 32'hA5A5_0004, 32'h0);
    cycle(); cycle();
    emwr_progfull = 1'b0;
    cycle();

    // random mix including idle cycles with garbage fields
    for (int i = 0; i < 24; i++) begin
      emwr_progfull = ($urandom_range(0, 3) == 0);
      emrq_progfull = ($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
            $urandom, $urandom, $urandom);
      cycle();
    end
    emwr_progfull = 1'b0; emrq_progfull = 1'b0;

    // 20 writes saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 2'd2, 4'h0, 32'h8E00_1000 + i, i, 32'h0);
      cycle();
    end
    check("wr_count4_sat", {60'd0, wr_cnt4}, 64'd15);

    // reset right after a pop drops everything
    drive(1'b1, 1'b1, 2'd2, 4'h0, 32'h8E00_2000, 32'hCAFE_0000, 32'h0);
    cycle();
    rstn = 1'b0;
    cycle();
    check("rst_wr_acc", {63'd0, wr_acc}, 64'd0);
    check("rst_wr_count", {48'd0, wr_cnt}, 64'd0);
    rstn = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 32'h0);
    cycle();

    // dstaddr remap window (identity without the macro)
    drive(1'b1, 1'b1, 2'd2, 4'h0, 32'h8080_0040, 32'h1111_0000, 32'h0);
    cycle();
    drive(1'b1, 1'b1, 2'd2, 4'h0, 32'h8090_0040, 32'h2222_0000, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 2'd2, 4'h0, 32'h8080_0080, 32'h0, 32'h8100_0008);
    cycle();
    drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 32'h0);
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/erx_disty.md
ERX_DISTY -- requirements
Module: erx_disty

Interface
REQ-001 SHALL have parameter CW, default 16: width of the saturating transaction counters.
REQ-002 SHALL have port m_axi_aclk  in  1  sole clock; all logic is on its rising edge.
REQ-003 SHALL have port m_axi_aresetn  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports rx_access/rx_write  in  1 each  head-of-FIFO valid and write/read flag (first-word-fall-through source).
REQ-005 SHALL have ports rx_datamode in 2, rx_ctrlmode in 4, rx_dstaddr/rx_data/rx_srcaddr in 32 each  head-of-FIFO packet fields.
REQ-006 SHALL have port rx_rd_en  out  1  pop strobe to the upstream FIFO.
REQ-007 SHALL have ports emwr_access/emwr_write out 1, emwr_datamode out 2, emwr_ctrlmode out 4, emwr_dstaddr/emwr_data/emwr_srcaddr out 32  write-FIFO write port.
REQ-008 SHALL have ports emrq_* out, same widths as emwr_*  read-request-FIFO write port.
REQ-009 SHALL have ports emwr_progfull/emrq_progfull  in  1 each  programmable-full from each FIFO.
REQ-010 SHALL have ports wr_count/rq_count  out  CW each  saturating counts of forwarded writes/reads.

Function
REQ-011 SHALL pop when rx_rd_en = rx_access & ~blocked, blocked = rx_write ? emwr_progfull : emrq_progfull.
REQ-012 SHALL register every popped packet to exactly one output port one cycle later: emwr_* if rx_write=1, else emrq_*.
REQ-013 SHALL drive emwr_access/emrq_access high for exactly one cycle per forwarded packet; never both in the same cycle.
REQ-014 SHALL pass datamode, ctrlmode, dstaddr, data, srcaddr unchanged (except REQ-022) and drive emwr_write=1, emrq_write=0.
REQ-015 SHALL hold all data outputs at last value when the access strobe is low.
REQ-016 SHALL stall a blocked head packet without reordering: a blocked read also blocks a following write (strict FIFO order).
REQ-017 SHALL sample progfull combinationally in the pop cycle; downstream FIFOs reserve >=2 entries of progfull slack.
REQ-018 SHALL increment wr_count/rq_count on the cycle the respective access strobe asserts; saturate at 2^CW-1, no wrap.
REQ-019 SHALL run a 2-state FSM: RUN (pop allowed) and HOLD (entered when a packet is blocked, rx_rd_en=0); HOLD->RUN on the cycle the blocking progfull deasserts, popping in that same cycle.
REQ-020 SHALL ignore rx_write and all fields while rx_access=0.

Reset
REQ-021 SHALL on m_axi_aresetn=0 at a clock edge: FSM=RUN, emwr_access=emrq_access=0, all emwr_*/emrq_* data fields=0, emwr_write=1, emrq_write=0, counters=0, rx_rd_en=0 combinationally while reset is low; reset mid-burst drops the in-flight registered packet.

Configuration
REQ-022 SHALL, with ERX_DISTY_REMAP_EN defined, add input cfg_remap[11:0] and replace dstaddr[31:20] with cfg_remap on both ports when rx_dstaddr[31:20]=12'h808; without the macro no port is added and dstaddr passes unchanged.

Verification
REQ-023 SHALL cover: write pkt dstaddr=0x8E000010, data=0xA5A5_0001, datamode=2 -> next cycle emwr_access=1 with identical fields, emrq_access=0, wr_count=1.
REQ-024 SHALL cover: read pkt srcaddr=0x8100_0000 followed by write -> emrq_access cycle N, emwr_access cycle N+1, rq_count=1, wr_count=1.
REQ-025 SHALL cover: emrq_progfull=1 with read at head and write behind -> rx_rd_en=0, FSM=HOLD, no outputs; deassert -> read forwarded first, write next cycle.
REQ-026 SHALL cover: CW=4, 20 writes -> wr_count stops at 15.
REQ-027 SHALL cover: reset asserted one cycle after a pop -> no emwr_access pulse, counters=0.
REQ-028 SHALL cover (macro on): cfg_remap=0x3E0, dstaddr=0x80800040 -> emwr_dstaddr=0x3E000040; dstaddr=0x80900040 unchanged.
